icache_fill: RTL and testbench
==============================

Name: icache_fill

Overview:
- Line-fill controller directly upstream of the instruction cache.
- On a cache miss (`pull`), it issues a line read to the nibble-wide external memory port and collects the returned nibbles into a local line buffer.
- It then replays the line to the cache as one contiguous burst on `dread`/`wstrobe_d`.
- The buffering is needed because the cache's internal nibble offset resets on any strobe gap, while the memory port may stall between nibbles.

Parameters:
- LINE_LENGTH, 4, cache line length in bytes; the line holds NNIB = LINE_LENGTH*2 nibbles.
- PA, 22, physical address width in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- pull  input  1  cache miss request for the line addressed by `tag`.
- tag  input  PA-$clog2(LINE_LENGTH)  line address of the miss.
- flush_all  input  1  cancel; also the fetch redirect.
- busy  output  1  fill in progress; fetch must hold `paddr` stable while this is high.
- mem_req  output  1  memory read request.
- mem_addr  output  PA  byte address of the line, `{tag, low zeros}`.
- mem_gnt  input  1  memory accepts the request.
- mem_rvalid  input  1  `mem_rdata` is valid this cycle.
- mem_rdata  input  4  returned nibble, high nibble of each byte first.
- dread  output  4  nibble to the cache.
- wstrobe_d  output  1  cache write strobe.

Behaviour:
- States: IDLE, REQ, COLLECT, WRITE, DRAIN.
- Counter `cnt` is $clog2(NNIB) bits and wraps naturally. Line buffer `buf` holds NNIB x 4 bits.
- Reset: state=IDLE, cnt=0. Outputs: busy=0, mem_req=0, wstrobe_d=0, dread=0, mem_addr=0.
- IDLE:
  - pull=1 and flush_all=0: latch `mem_addr = {tag, 0}`, cnt=0, go to REQ.
  - pull=1 together with flush_all=1: ignored.
- REQ:
  - mem_req=1 and busy=1; mem_addr is held stable until the grant.
  - mem_gnt=1: go to COLLECT, cnt=0. mem_req drops in the cycle after the grant.
- COLLECT:
  - Each cycle with mem_rvalid=1: buf[cnt]=mem_rdata, cnt++. Gaps of any length are allowed.
  - Beat with mem_rvalid=1 and cnt==NNIB-1: go to WRITE, cnt=0.
- WRITE:
  - Exactly NNIB consecutive cycles with wstrobe_d=1 and dread=buf[cnt], cnt++. No gaps are permitted.
  - The nibble on the k-th strobe cycle is the k-th nibble received from memory.
  - After the cycle with cnt==NNIB-1: go to IDLE, wstrobe_d=0.
  - IDLE then ignores pull for one cycle, so the cache has time to assert hit. This prevents a duplicate fill.
- Latency: with gnt in the same cycle as req and back-to-back rvalid, first strobe is 1 (REQ) + NNIB (COLLECT) cycles after the pull is sampled; an NNIB=8 fill occupies 1+8+8 busy cycles.
- busy=1 in REQ, COLLECT and WRITE. busy=0 in IDLE and DRAIN.
- flush_all:
  - In REQ: the request cannot be withdrawn once asserted. Keep mem_req until gnt, then go to DRAIN.
  - In COLLECT: go to DRAIN, keeping cnt.
  - In WRITE: stop immediately, wstrobe_d=0 from the next cycle, go to IDLE. The cache invalidates the partial line through its own flush.
- DRAIN: consume the remaining rvalid beats up to NNIB total, discard them, never strobe, then go to IDLE. A new pull is not accepted until DRAIN exits.
- Reset mid-operation: state returns to IDLE. The memory side is reset by the same reset.
- mem_rvalid outside COLLECT/DRAIN: ignored.

Decomposition:
- Shared package holds:
  - fill state enum (IDLE/REQ/COLLECT/WRITE/DRAIN);
  - NNIB and NIB_W=$clog2(NNIB) derivation from LINE_LENGTH;
  - the line-address width expression PA-$clog2(LINE_LENGTH), shared with the cache.
- Optional sub-module `nibble_line_buf`: NNIB x 4 register file with a write port (cnt, data, we) and an asynchronous read port. It is reusable for a future data cache.

Test Plan:
- Basic fill: tag=0x12345 (PA=22, LINE=4), pull=1, gnt in the REQ cycle, rvalid nibbles 1..8 back-to-back.
  - mem_addr=0x48D14; mem_req is high for 1 cycle.
  - 8 contiguous strobes carry dread=1,2,...,8; busy=0 after; the cache hits at `paddr` 0x48D14.
- Stalled memory: same as basic fill, with rvalid gaps of 0, 3 and 1 cycles between nibbles and gnt delayed 5 cycles.
  - mem_addr is stable for all 6 REQ cycles; the strobe burst is still exactly 8 contiguous cycles with the correct order.
- Flush during COLLECT: flush_all after nibble 3.
  - Remaining 5 beats are consumed with no wstrobe_d.
  - Next pull (tag=0x00001) gives mem_addr=0x000004 only after DRAIN exits.
- Flush during WRITE: flush_all on the 4th strobe.
  - wstrobe_d=0 next cycle and state IDLE; a subsequent pull starts a fresh request.
- No refill: pull held high across the end of WRITE.
  - The one-cycle IDLE guard yields no second mem_req when the cache hits.
- Reset mid-REQ and mid-WRITE: every output returns to its reset value on the next edge; no strobes follow.

Source files
------------

// File: rtl/icache_fill_pkg.sv
// Shared definitions for the instruction-cache line-fill path: fill states and
// the nibble/line-address geometry derived from the cache line length.
package icache_fill_pkg;

  localparam int LINE_LENGTH_DFLT = 4;
  localparam int PA_DFLT          = 22;

  function automatic int nnib_of(input int line_length);
    return line_length * 2;
  endfunction

  function automatic int nib_w_of(input int line_length);
    return $clog2(line_length * 2);
  endfunction

  // Line address width, also used by the cache tag path.
  function automatic int line_addr_w(input int pa, input int line_length);
    return pa - $clog2(line_length);
  endfunction

  localparam int NNIB        = nnib_of(LINE_LENGTH_DFLT);
  localparam int NIB_W       = nib_w_of(LINE_LENGTH_DFLT);
  localparam int LINE_ADDR_W = line_addr_w(PA_DFLT, LINE_LENGTH_DFLT);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COLLECT,
    WRITE,
    DRAIN
  } fill_state_t;

endpackage

// File: rtl/icache_fill_nibble_line_buf.sv
// NNIB x 4-bit line register file: one synchronous write port, one
// asynchronous read port. Holds data only, so it carries no reset.
module nibble_line_buf #(
  parameter int NNIB  = 8,
  parameter int NIB_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [NIB_W-1:0] waddr,
  input  logic [3:0]       wdata,
  input  logic [NIB_W-1:0] raddr,
  output logic [3:0]       rdata
);

  logic [3:0] line_q [NNIB];

  always_ff @(posedge clk) begin
    if (we) line_q[waddr] <= wdata;
  end

  assign rdata = line_q[raddr];

endmodule

// File: rtl/icache_fill.sv
// Instruction-cache line fill: fetches a line nibble by nibble from a stallable
// memory port, then replays it to the cache as one gap-free strobe burst.
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int LINE_LENGTH = LINE_LENGTH_DFLT,
  parameter int PA          = PA_DFLT
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     pull,
  input  logic [line_addr_w(PA, LINE_LENGTH)-1:0]  tag,
  input  logic                                     flush_all,
  output logic                                     busy,
  output logic                                     mem_req,
  output logic [PA-1:0]                            mem_addr,
  input  logic                                     mem_gnt,
  input  logic                                     mem_rvalid,
  input  logic [3:0]                               mem_rdata,
  output logic [3:0]                               dread,
  output logic                                     wstrobe_d
);

  localparam int NN    = nnib_of(LINE_LENGTH);
  localparam int NW    = nib_w_of(LINE_LENGTH);
  localparam int OFF_W = $clog2(LINE_LENGTH);
  localparam logic [NW-1:0] LAST = NW'(NN - 1);

  fill_state_t   state, state_next;
  logic [NW-1:0] cnt, cnt_next;
  logic          guard, guard_next;
  logic          abort, abort_next;
  logic [PA-1:0] addr_next;
  logic          buf_we;
  logic [3:0]    buf_rdata;

  nibble_line_buf #(
    .NNIB  (NN),
    .NIB_W (NW)
  ) u_line_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (mem_rdata),
    .raddr (cnt),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      guard    <= 1'b0;
      abort    <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      guard    <= guard_next;
      abort    <= abort_next;
      mem_addr <= addr_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    guard_next = 1'b0;
    abort_next = 1'b0;
    addr_next  = mem_addr;
    busy       = 1'b0;
    mem_req    = 1'b0;
    wstrobe_d  = 1'b0;
    dread      = 4'h0;
    buf_we     = 1'b0;
    unique case (state)
      IDLE: begin
        // guard covers the cycle the cache needs to see its own hit
        if (pull && !flush_all && !guard) begin
          addr_next  = {tag, {OFF_W{1'b0}}};
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // a request already on the bus cannot be withdrawn; remember the cancel
        abort_next = abort | flush_all;
        if (mem_gnt) begin
          cnt_next   = '0;
          state_next = (abort || flush_all) ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          buf_we   = 1'b1;
          cnt_next = cnt + NW'(1);
          if (cnt == LAST)    state_next = flush_all ? IDLE : WRITE;
          else if (flush_all) state_next = DRAIN;
        end else if (flush_all) begin
          state_next = DRAIN;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        wstrobe_d = 1'b1;
        dread     = buf_rdata;
        cnt_next  = cnt + NW'(1);
        if (flush_all) begin
          state_next = IDLE;
        end else if (cnt == LAST) begin
          state_next = IDLE;
          guard_next = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          cnt_next = cnt + NW'(1);
          if (cnt == LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: scripted fills plus random traffic against a
// transaction-level model of the fill controller and a stallable memory.
module tb_icache_fill;

  localparam int LL = 4;
  localparam int PA = 22;
  localparam int NN = LL * 2;
  localparam int TW = PA - $clog2(LL);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pull = 1'b0;
  logic          flush_all = 1'b0;
  logic [TW-1:0] tag = '0;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [3:0]    mem_rdata = 4'h0;
  logic          busy, mem_req, wstrobe_d;
  logic [PA-1:0] mem_addr;
  logic [3:0]    dread;

  icache_fill #(.LINE_LENGTH(LL), .PA(PA)) dut (
    .clk(clk), .reset(reset), .pull(pull), .tag(tag), .flush_all(flush_all),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dread(dread), .wstrobe_d(wstrobe_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait expired, want completion", name);
  endtask

  // ---------------- memory responder ----------------
  bit         rand_mode = 1'b0;
  int         gnt_dly_cfg = 0;
  int         gap_cfg [NN];
  logic [3:0] data_cfg [NN];
  int         rs = 0, dly = 0, beat = 0, gapc = 0;
  bit         rst_s;
  bit         resp_busy = 1'b0;

  task automatic randomize_cfg();
    gnt_dly_cfg = $urandom_range(0, 3);
    for (int i = 0; i < NN; i++) begin
      gap_cfg[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      data_cfg[i] = 4'($urandom);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 4'h0;
      if (rst_s) rs = 0;
      else begin
        if (rs == 0 && mem_req) begin
          if (rand_mode) randomize_cfg();
          dly = gnt_dly_cfg;
          rs  = 1;
        end
        if (rs == 1) begin
          if (dly == 0) begin
            mem_gnt = 1'b1; rs = 2; beat = 0; gapc = gap_cfg[0];
          end else dly--;
        end else if (rs == 2) begin
          if (gapc > 0) gapc--;
          else begin
            mem_rvalid = 1'b1;
            mem_rdata  = data_cfg[beat];
            beat++;
            if (beat == NN) rs = 0;
            else gapc = gap_cfg[beat];
          end
        end
      end
      resp_busy = (rs != 0);
    end
  end

  // ---------------- reference model ----------------
  // A fill is: wait for grant, count down NNIB beats (kept unless cancelled),
  // then emit the kept nibbles in arrival order, then one ignored-pull cycle.
  bit            m_wait = 1'b0, m_abort = 1'b0, m_guard = 1'b0;
  int            m_beats = 0, m_strobes = 0;
  logic [3:0]    m_line [$];
  logic [PA-1:0] m_addr = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_wait = 1'b0; m_abort = 1'b0; m_guard = 1'b0;
      m_beats = 0; m_strobes = 0; m_addr = '0; m_line.delete();
    end else if (m_wait) begin
      if (flush_all) m_abort = 1'b1;
      if (mem_gnt) begin m_wait = 1'b0; m_beats = NN; end
    end else if (m_beats > 0) begin
      if (mem_rvalid) begin
        m_beats--;
        if (!m_abort) m_line.push_back(mem_rdata);
      end
      if (flush_all) m_abort = 1'b1;
      if (m_beats == 0 && !m_abort) m_strobes = NN;
    end else if (m_strobes > 0) begin
      void'(m_line.pop_front());
      m_strobes--;
      if (flush_all) m_strobes = 0;
      else if (m_strobes == 0) m_guard = 1'b1;
    end else if (m_guard) begin
      m_guard = 1'b0;
    end else if (pull && !flush_all) begin
      m_addr  = {tag, {$clog2(LL){1'b0}}};
      m_wait  = 1'b1;
      m_abort = 1'b0;
      m_line.delete();
    end
  end

  always @(posedge clk) cyc++;

  // ---------------- per-cycle compare and monitors ----------------
  int            beats_total, strobes_total, req_total, busy_total, strobe_runs;
  int            first_strobe_cyc, addr_moves;
  logic [PA-1:0] last_req_addr;
  logic [3:0]    sq [$];
  bit            prev_strobe = 1'b0, prev_req = 1'b0;
  logic          e_busy, e_strobe;
  logic [3:0]    e_dread;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_busy   = m_wait || (m_beats > 0 && !m_abort) || (m_strobes > 0);
      e_strobe = (m_strobes > 0);
      e_dread  = e_strobe ? m_line[0] : 4'h0;
      chk("outputs{busy,req,strobe,dread,addr}",
          {3'b0, busy, mem_req, wstrobe_d, dread, mem_addr},
          {3'b0, e_busy, m_wait, e_strobe, e_dread, m_addr});
    end
    if (mem_rvalid) beats_total++;
    if (busy) busy_total++;
    if (mem_req) begin
      req_total++;
      if (!prev_req) last_req_addr = mem_addr;
      else if (mem_addr !== last_req_addr) addr_moves++;
    end
    if (wstrobe_d) begin
      strobes_total++;
      sq.push_back(dread);
      if (!prev_strobe) begin
        strobe_runs++;
        if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      end
    end
    prev_strobe = wstrobe_d;
    prev_req    = mem_req;
  end

  task automatic clear_mon();
    beats_total = 0; strobes_total = 0; req_total = 0; busy_total = 0;
    strobe_runs = 0; first_strobe_cyc = -1; addr_moves = 0;
    last_req_addr = '0; sq.delete();
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while ((busy || resp_busy || m_wait || m_beats > 0 || m_strobes > 0) && k < max) begin
      step(); k++;
    end
    if (k >= max) timeout(name);
    repeat (2) step();
  endtask

  task automatic set_basic_cfg(input int dly_c);
    rand_mode = 1'b0;
    gnt_dly_cfg = dly_c;
    for (int i = 0; i < NN; i++) begin
      gap_cfg[i]  = 0;
      data_cfg[i] = 4'(i + 1);
    end
  endtask

  task automatic check_line(input string name);
    chk({name, "_strobes"}, strobes_total, NN);
    chk({name, "_runs"}, strobe_runs, 1);
    for (int i = 0; i < NN && i < sq.size(); i++)
      chk($sformatf("%s_nib%0d", name, i), sq[i], i + 1);
  endtask

  initial begin
    #(10 * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pc, k;
    clear_mon();
    set_basic_cfg(0);
    step();
    cmp_en = 1'b1;
    chk("reset_outputs", {busy, mem_req, wstrobe_d, dread, mem_addr}, 32'h0);
    reset = 1'b0;
    step();

    // basic fill
    clear_mon();
    tag = 20'h12345; pull = 1'b1; pc = cyc;
    step(); pull = 1'b0;
    wait_idle("basic_idle", 60);
    chk("basic_addr", last_req_addr, 22'h48D14);
    chk("basic_req_cycles", req_total, 1);
    chk("basic_busy_cycles", busy_total, 17);
    chk("basic_latency", first_strobe_cyc - pc, 10);
    check_line("basic");

    // stalled memory: grant after 5 extra cycles, gaps 0,3,1 between nibbles
    set_basic_cfg(5);
    gap_cfg[2] = 3; gap_cfg[3] = 1;
    clear_mon();
    pull = 1'b1;
    step(); pull = 1'b0;
    wait_idle("stall_idle", 80);
    chk("stall_req_cycles", req_total, 6);
    chk("stall_addr", last_req_addr, 22'h48D14);
    chk("stall_addr_moves", addr_moves, 0);
    chk("stall_busy_cycles", busy_total, 26);
    check_line("stall");

    // flush during COLLECT after nibble 3, new pull waits for drain
    set_basic_cfg(0);
    gap_cfg[3] = 2;
    clear_mon();
    pull = 1'b1;
    step(); pull = 1'b0;
    k = 0;
    while (beats_total < 3 && k < 40) begin step(); k++; end
    if (k >= 40) timeout("fc_beats");
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    chk("fc_drain_busy", busy, 0);
    tag = 20'h00001; pull = 1'b1;
    k = 0;
    while (!mem_req && k < 40) begin step(); k++; end
    if (k >= 40) timeout("fc_new_req");
    pull = 1'b0;
    chk("fc_beats_before_req", beats_total, NN);
    chk("fc_strobes_before_req", strobes_total, 0);
    chk("fc_new_addr", mem_addr, 22'h000004);
    wait_idle("fc_idle", 80);

    // flush during WRITE on the 4th strobe
    set_basic_cfg(0);
    clear_mon();
    tag = 20'h12345; pull = 1'b1;
    step(); pull = 1'b0;
    k = 0;
    while (strobes_total < 3 && k < 60) begin step(); k++; end
    if (k >= 60) timeout("fw_strobes");
    chk("fw_strobe4", wstrobe_d, 1);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    chk("fw_stop", wstrobe_d, 0);
    chk("fw_busy", busy, 0);
    repeat (3) step();
    chk("fw_strobe_count", strobes_total, 4);
    clear_mon();
    tag = 20'h2AAAA; pull = 1'b1;
    step(); pull = 1'b0;
    wait_idle("fw_idle", 60);
    chk("fw_new_addr", last_req_addr, 22'hAAAA8);
    chk("fw_new_req", req_total, 1);
    check_line("fw_refill");

    // pull held across the end of WRITE: guard cycle, then cache hits
    clear_mon();
    tag = 20'h0F0F0; pull = 1'b1;
    k = 0;
    while (strobes_total < NN && k < 60) begin step(); k++; end
    if (k >= 60) timeout("nr_strobes");
    step(); pull = 1'b0;
    repeat (5) step();
    chk("nr_req_cycles", req_total, 1);

    // reset mid-REQ
    set_basic_cfg(5);
    clear_mon();
    pull = 1'b1;
    step(); pull = 1'b0;
    step();
    chk("rq_in_req", mem_req, 1);
    reset = 1'b1;
    step();
    chk("rq_reset_outputs", {busy, mem_req, wstrobe_d, dread, mem_addr}, 32'h0);
    reset = 1'b0;
    repeat (30) step();
    chk("rq_no_strobes", strobes_total, 0);

    // reset mid-WRITE
    set_basic_cfg(0);
    clear_mon();
    pull = 1'b1;
    step(); pull = 1'b0;
    k = 0;
    while (!wstrobe_d && k < 40) begin step(); k++; end
    if (k >= 40) timeout("rw_strobe");
    reset = 1'b1;
    step();
    chk("rw_reset_outputs", {busy, mem_req, wstrobe_d, dread, mem_addr}, 32'h0);
    reset = 1'b0;
    repeat (15) step();
    chk("rw_no_more_strobes", strobes_total, 1);

    // random traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      pull      = ($urandom_range(0, 3) == 0);
      flush_all = ($urandom_range(0, 24) == 0);
      tag       = TW'($urandom);
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    pull = 1'b0; flush_all = 1'b0; reset = 1'b0;
    wait_idle("rand_idle", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
